// File: rtl/csr_trap_unit.sv
// ---------------------------------------------------------------------------
// csr_trap_unit
//   Machine-mode CSR file with trap entry/return sequencing, RW/RS/RC CSR ops,
//   64-bit mcycle/minstret counters, vectored mtvec and local interrupts.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   csr_valid/op/addr   CSR access from execute (op: 01 RW, 10 RS, 11 RC)
//   csr_wdata           CSR operand
//   csr_rdata           pre-write CSR value, 0 on illegal access (comb)
//   csr_illegal         access is illegal (comb)
//   m_ext/timer/soft_irq, local_irq   level interrupt inputs
//   irq_pending         an enabled interrupt is pending (comb from registers)
//   irq_cause           cause code of the highest-priority pending interrupt
//   exc_valid/cause/pc/tval  synchronous exception from commit
//   irq_take            commit takes irq_cause; its PC is on exc_pc
//   mret                commit MRET
//   instret_inc         one instruction retired
//   trap_vector         target PC for the current trap (comb)
//   mepc_o              mepc, used as the MRET target
//   priv                current privilege level
// ---------------------------------------------------------------------------
module csr_trap_unit #(
    parameter int unsigned XLEN          = 32,
    parameter int unsigned NUM_LOCAL_IRQ = 4,
    parameter bit          SUPPORT_U     = 1'b1,
    parameter logic [31:0] RESET_MTVEC   = 32'h8000_0000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 csr_valid,
    input  logic [1:0]           csr_op,
    input  logic [11:0]          csr_addr,
    input  logic [XLEN-1:0]      csr_wdata,
    output logic [XLEN-1:0]      csr_rdata,
    output logic                 csr_illegal,
    input  logic                 m_ext_irq,
    input  logic                 m_timer_irq,
    input  logic                 m_soft_irq,
    input  logic [((NUM_LOCAL_IRQ == 0) ? 1 : NUM_LOCAL_IRQ)-1:0] local_irq,
    output logic                 irq_pending,
    output logic [4:0]           irq_cause,
    input  logic                 exc_valid,
    input  logic [4:0]           exc_cause,
    input  logic [XLEN-1:0]      exc_pc,
    input  logic [XLEN-1:0]      exc_tval,
    input  logic                 irq_take,
    input  logic                 mret,
    input  logic                 instret_inc,
    output logic [XLEN-1:0]      trap_vector,
    output logic [XLEN-1:0]      mepc_o,
    output logic [1:0]           priv
);

    localparam logic [1:0] OP_RW = 2'b01;
    localparam logic [1:0] OP_RS = 2'b10;
    localparam logic [1:0] OP_RC = 2'b11;

    localparam logic [1:0] PRIV_U = 2'b00;
    localparam logic [1:0] PRIV_M = 2'b11;

    localparam logic [11:0] A_MSTATUS    = 12'h300;
    localparam logic [11:0] A_MISA       = 12'h301;
    localparam logic [11:0] A_MIE        = 12'h304;
    localparam logic [11:0] A_MTVEC      = 12'h305;
    localparam logic [11:0] A_MCOUNTEREN = 12'h306;
    localparam logic [11:0] A_MSCRATCH   = 12'h340;
    localparam logic [11:0] A_MEPC       = 12'h341;
    localparam logic [11:0] A_MCAUSE     = 12'h342;
    localparam logic [11:0] A_MTVAL      = 12'h343;
    localparam logic [11:0] A_MIP        = 12'h344;
    localparam logic [11:0] A_MCYCLE     = 12'hB00;
    localparam logic [11:0] A_MINSTRET   = 12'hB02;
    localparam logic [11:0] A_MCYCLEH    = 12'hB80;
    localparam logic [11:0] A_MINSTRETH  = 12'hB82;
    localparam logic [11:0] A_CYCLE      = 12'hC00;
    localparam logic [11:0] A_INSTRET    = 12'hC02;
    localparam logic [11:0] A_CYCLEH     = 12'hC80;
    localparam logic [11:0] A_INSTRETH   = 12'hC82;

    localparam logic [31:0] MISA_VAL = 32'h4000_1100 | (SUPPORT_U ? 32'h0010_0000 : 32'h0);
    // Writable mie bits: MEI, MTI, MSI and one bit per local line at 16+i
    localparam logic [31:0] IRQ_MASK =
        32'h0000_0888 | (((32'(1) << NUM_LOCAL_IRQ) - 32'd1) << 16);

    // Architectural state
    logic        mstatus_mie;
    logic        mstatus_mpie;
    logic [1:0]  mstatus_mpp;
    logic [31:0] mie_q;
    logic [31:0] mtvec_q;
    logic [31:0] mcounteren_q;
    logic [31:0] mscratch_q;
    logic [31:0] mepc_q;
    logic        mcause_irq;
    logic [4:0]  mcause_code;
    logic [31:0] mtval_q;
    logic [31:0] mip_q;
    logic [63:0] mcycle_q;
    logic [63:0] minstret_q;
    logic [1:0]  priv_q;

    // Combinational decode
    logic [31:0] mip_d;
    logic [31:0] mstatus_rd;
    logic [31:0] rdata_raw;
    logic        addr_impl;
    logic        is_cy_ctr;
    logic        is_ir_ctr;
    logic        wr_intent;
    logic        ill_c;
    logic        csr_we;
    logic [31:0] wval;
    logic [31:0] pend_vec;
    logic        trap_take;
    logic        trap_is_irq;
    logic [4:0]  trap_cause;
    logic        mret_take;
    logic [31:0] mtvec_base;
    logic [63:0] mcycle_d;
    logic [63:0] minstret_d;

    // Map interrupt inputs onto their mip bit positions
    always_comb begin
        mip_d     = '0;
        mip_d[11] = m_ext_irq;
        mip_d[7]  = m_timer_irq;
        mip_d[3]  = m_soft_irq;
        for (int i = 0; i < int'(NUM_LOCAL_IRQ); i++) begin
            mip_d[16+i] = local_irq[i];
        end
    end

    assign mstatus_rd = {19'b0, mstatus_mpp, 3'b0, mstatus_mpie, 3'b0, mstatus_mie, 3'b0};

    // CSR read mux and address decode
    always_comb begin
        addr_impl = 1'b1;
        rdata_raw = '0;
        case (csr_addr)
            A_MSTATUS:              rdata_raw = mstatus_rd;
            A_MISA:                 rdata_raw = MISA_VAL;
            A_MIE:                  rdata_raw = mie_q;
            A_MTVEC:                rdata_raw = mtvec_q;
            A_MCOUNTEREN:           rdata_raw = mcounteren_q;
            A_MSCRATCH:             rdata_raw = mscratch_q;
            A_MEPC:                 rdata_raw = mepc_q;
            A_MCAUSE:               rdata_raw = {mcause_irq, 26'b0, mcause_code};
            A_MTVAL:                rdata_raw = mtval_q;
            A_MIP:                  rdata_raw = mip_q;
            A_MCYCLE, A_CYCLE:      rdata_raw = mcycle_q[31:0];
            A_MCYCLEH, A_CYCLEH:    rdata_raw = mcycle_q[63:32];
            A_MINSTRET, A_INSTRET:  rdata_raw = minstret_q[31:0];
            A_MINSTRETH, A_INSTRETH: rdata_raw = minstret_q[63:32];
            default:                addr_impl = 1'b0;
        endcase
    end

    assign is_cy_ctr = (csr_addr == A_CYCLE)   || (csr_addr == A_CYCLEH);
    assign is_ir_ctr = (csr_addr == A_INSTRET) || (csr_addr == A_INSTRETH);

    // RS/RC with a zero operand is a pure read
    assign wr_intent = (csr_op == OP_RW) ||
                       (((csr_op == OP_RS) || (csr_op == OP_RC)) && (csr_wdata != '0));

    assign ill_c = !addr_impl
                || (wr_intent && (csr_addr[11:10] == 2'b11))
                || (priv_q < csr_addr[9:8])
                || ((priv_q == PRIV_U) &&
                    ((is_cy_ctr && !mcounteren_q[0]) || (is_ir_ctr && !mcounteren_q[2])));

    assign csr_illegal = csr_valid && ill_c;
    assign csr_rdata   = csr_illegal ? '0 : rdata_raw;

    // New value for the addressed CSR
    always_comb begin
        wval = rdata_raw;
        case (csr_op)
            OP_RW:   wval = csr_wdata;
            OP_RS:   wval = rdata_raw | csr_wdata;
            OP_RC:   wval = rdata_raw & ~csr_wdata;
            default: wval = rdata_raw;
        endcase
    end

    // Interrupt selection: MEI > MSI > MTI > local, lowest local index first
    assign pend_vec    = mip_q & mie_q;
    assign irq_pending = (pend_vec != '0) && ((priv_q != PRIV_M) || mstatus_mie);

    always_comb begin
        irq_cause = '0;
        for (int i = int'(NUM_LOCAL_IRQ) - 1; i >= 0; i--) begin
            if (pend_vec[16+i]) begin
                irq_cause = 5'(16 + i);
            end
        end
        if (pend_vec[7])  irq_cause = 5'd7;
        if (pend_vec[3])  irq_cause = 5'd3;
        if (pend_vec[11]) irq_cause = 5'd11;
    end

    // Trap arbitration: exception beats interrupt, any trap beats mret and CSR writes
    assign trap_take   = exc_valid || (irq_take && irq_pending);
    assign trap_is_irq = !exc_valid;
    assign trap_cause  = exc_valid ? exc_cause : irq_cause;
    assign mret_take   = mret && !trap_take;
    assign csr_we      = csr_valid && !ill_c && wr_intent && !trap_take;

    assign mtvec_base  = {mtvec_q[31:2], 2'b00};
    assign trap_vector = (mtvec_q[0] && trap_is_irq) ? (mtvec_base + {25'b0, irq_cause, 2'b00})
                                                      : mtvec_base;

    // Counter next values; a CSR write replaces only its own half
    always_comb begin
        mcycle_d   = mcycle_q + 64'd1;
        minstret_d = minstret_q + 64'(instret_inc);
        if (csr_we && (csr_addr == A_MCYCLE))     mcycle_d[31:0]    = wval;
        if (csr_we && (csr_addr == A_MCYCLEH))    mcycle_d[63:32]   = wval;
        if (csr_we && (csr_addr == A_MINSTRET))   minstret_d[31:0]  = wval;
        if (csr_we && (csr_addr == A_MINSTRETH))  minstret_d[63:32] = wval;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcycle_q   <= '0;
            minstret_q <= '0;
            mip_q      <= '0;
        end else begin
            mcycle_q   <= mcycle_d;
            minstret_q <= minstret_d;
            mip_q      <= mip_d;
        end
    end

    // CSR writes, then trap entry / mret which take precedence
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mstatus_mie  <= 1'b0;
            mstatus_mpie <= 1'b0;
            mstatus_mpp  <= SUPPORT_U ? PRIV_U : PRIV_M;
            mie_q        <= '0;
            mtvec_q      <= RESET_MTVEC & ~32'h2;
            mcounteren_q <= '0;
            mscratch_q   <= '0;
            mepc_q       <= '0;
            mcause_irq   <= 1'b0;
            mcause_code  <= '0;
            mtval_q      <= '0;
            priv_q       <= PRIV_M;
        end else begin
            if (csr_we) begin
                case (csr_addr)
                    A_MSTATUS: begin
                        mstatus_mie  <= wval[3];
                        mstatus_mpie <= wval[7];
                        // Only M and U are supported; anything but 00 lands in M
                        mstatus_mpp  <= (SUPPORT_U && (wval[12:11] == PRIV_U)) ? PRIV_U : PRIV_M;
                    end
                    A_MIE:        mie_q        <= wval & IRQ_MASK;
                    A_MTVEC:      mtvec_q      <= wval & ~32'h2;
                    A_MCOUNTEREN: mcounteren_q <= wval;
                    A_MSCRATCH:   mscratch_q   <= wval;
                    A_MEPC:       mepc_q       <= wval & ~32'h3;
                    A_MCAUSE: begin
                        mcause_irq  <= wval[31];
                        mcause_code <= wval[4:0];
                    end
                    A_MTVAL:      mtval_q      <= wval;
                    default: ;
                endcase
            end

            if (trap_take) begin
                mepc_q       <= exc_pc & ~32'h3;
                mcause_irq   <= trap_is_irq;
                mcause_code  <= trap_cause;
                mtval_q      <= trap_is_irq ? '0 : exc_tval;
                mstatus_mpie <= mstatus_mie;
                mstatus_mie  <= 1'b0;
                mstatus_mpp  <= priv_q;
                priv_q       <= PRIV_M;
            end else if (mret_take) begin
                priv_q       <= mstatus_mpp;
                mstatus_mie  <= mstatus_mpie;
                mstatus_mpie <= 1'b1;
                mstatus_mpp  <= SUPPORT_U ? PRIV_U : PRIV_M;
            end
        end
    end

    assign mepc_o = mepc_q;
    assign priv   = priv_q;

endmodule
